// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
// Imported by the interface, the picker and the arbiter top.
package uart_tx_arbiter_pkg;

    parameter int DATA_WIDTH = 8;
    parameter int NO_OF_REQUESTERS = 4;

    typedef enum logic {
        EVEN_PARITY = 1'b0,
        ODD_PARITY  = 1'b1
    } parityTypeEnum;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_DONE = 2'd2,
        ARB_GAP       = 2'd3
    } UartArbiterStateEnum;

    // Index reached by stepping forward from base, wrapping at n.
    function automatic int rrIndex(
        input int base,
        input int step,
        input int n
    );
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and status bundle around the UART arbiter.
// master = surrounding system, slave = the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = uart_tx_arbiter_pkg::NO_OF_REQUESTERS,
    parameter int DATA_WIDTH = uart_tx_arbiter_pkg::DATA_WIDTH
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] reqValid;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0] reqReady;

    logic cfgParityEnable;
    logic cfgParityType;

    logic txStart;
    logic [DATA_WIDTH-1:0] txData;
    logic txParityEnable;
    logic txParityType;
    logic txDone;

    logic grantValid;
    logic [IDW-1:0] grantId;
    logic timeoutError;

    modport master (
        output reqValid,
        output reqData,
        output cfgParityEnable,
        output cfgParityType,
        output txDone,
        input reqReady,
        input txStart,
        input txData,
        input txParityEnable,
        input txParityType,
        input grantValid,
        input grantId,
        input timeoutError
    );

    modport slave (
        input reqValid,
        input reqData,
        input cfgParityEnable,
        input cfgParityType,
        input txDone,
        output reqReady,
        output txStart,
        output txData,
        output txParityEnable,
        output txParityType,
        output grantValid,
        output grantId,
        output timeoutError
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid requester above lastGrant,
// wrapping, reported both one-hot and as an index.
module uart_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input logic [NUM_REQ-1:0] reqValid,
    input logic [$clog2(NUM_REQ)-1:0] lastGrant,
    output logic [NUM_REQ-1:0] grantOneHot,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic anyValid
);

    import uart_tx_arbiter_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);

    always_comb begin
        grantOneHot = '0;
        winner = '0;
        anyValid = 1'b0;
        // Step k = NUM_REQ lands back on lastGrant, so it is searched last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!anyValid
                && reqValid[rrIndex(int'(lastGrant), k, NUM_REQ)]) begin
                anyValid = 1'b1;
                winner = IDW'(rrIndex(int'(lastGrant), k, NUM_REQ));
                grantOneHot[rrIndex(int'(lastGrant), k, NUM_REQ)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a single UART transmitter: accepts one byte per
// grant, starts the frame, and waits for done or the watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ = uart_tx_arbiter_pkg::NO_OF_REQUESTERS,
    parameter int DATA_WIDTH = uart_tx_arbiter_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    uart_tx_arbiter_if.slave bus
);

    import uart_tx_arbiter_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GPW =
        (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);
    localparam logic [GPW-1:0] GAP_LAST =
        GPW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] sIdle = ARB_IDLE;
    localparam logic [1:0] sIssue = ARB_ISSUE;
    localparam logic [1:0] sWait = ARB_WAIT_DONE;
    localparam logic [1:0] sGap = ARB_GAP;

    logic [1:0] state;
    logic [1:0] stateNext;

    logic [IDW-1:0] lastGrant;
    logic [IDW-1:0] winner;
    logic [NUM_REQ-1:0] pickOneHot;
    logic anyValid;
    logic [DATA_WIDTH-1:0] pickedData;

    logic [WDW-1:0] wdCnt;
    logic [GPW-1:0] gapCnt;

    logic accept;
    logic wdExpire;
    logic frameEnd;

    logic [DATA_WIDTH-1:0] dataQ;
    logic parEnQ;
    parityTypeEnum parTypeQ;
    logic grantValidQ;
    logic [IDW-1:0] grantIdQ;

    uart_rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) picker (
        .reqValid(bus.reqValid),
        .lastGrant(lastGrant),
        .grantOneHot(pickOneHot),
        .winner(winner),
        .anyValid(anyValid)
    );

    always_comb begin
        pickedData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickOneHot[i]) begin
                pickedData = bus.reqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept = !reset && (state == sIdle) && anyValid;
    assign wdExpire = (state == sWait) && (wdCnt == WD_LAST);
    assign frameEnd = (state == sWait) && (bus.txDone || wdExpire);

    always_comb begin
        stateNext = state;
        unique case (state)
            sIdle: begin
                if (anyValid) stateNext = sIssue;
            end
            sIssue: begin
                stateNext = sWait;
            end
            sWait: begin
                if (frameEnd) begin
                    stateNext = (GAP_CYCLES == 0) ? sIdle : sGap;
                end
            end
            sGap: begin
                if (gapCnt == GAP_LAST) stateNext = sIdle;
            end
            default: begin
                stateNext = sIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= sIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Starting at NUM_REQ-1 gives requester 0 first turn after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant <= IDW'(NUM_REQ - 1);
            grantIdQ <= '0;
        end else if (accept) begin
            lastGrant <= winner;
            grantIdQ <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dataQ <= '0;
            parEnQ <= 1'b0;
            parTypeQ <= EVEN_PARITY;
        end else if (accept) begin
            dataQ <= pickedData;
            parEnQ <= bus.cfgParityEnable;
            parTypeQ <= parityTypeEnum'(bus.cfgParityType);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grantValidQ <= 1'b0;
        end else if (accept) begin
            grantValidQ <= 1'b1;
        end else if (frameEnd) begin
            grantValidQ <= 1'b0;
        end
    end

    // Saturating watchdog, cleared while the start pulse is out.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdCnt <= '0;
        end else if (state == sIssue) begin
            wdCnt <= '0;
        end else if (state == sWait && wdCnt != WD_MAX) begin
            wdCnt <= wdCnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gapCnt <= '0;
        end else if (frameEnd) begin
            gapCnt <= '0;
        end else if (state == sGap) begin
            gapCnt <= gapCnt + 1'b1;
        end
    end

    // Pulses are masked during reset so an aborted frame emits nothing.
    assign bus.reqReady =
        (!reset && state == sIdle) ? pickOneHot : '0;
    assign bus.txStart = !reset && (state == sIssue);
    assign bus.timeoutError = !reset && wdExpire && !bus.txDone;

    assign bus.txData = dataQ;
    assign bus.txParityEnable = parEnQ;
    assign bus.txParityType = parTypeQ;
    assign bus.grantValid = grantValidQ;
    assign bus.grantId = grantIdQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table plus hand-run
// fairness, watchdog and coincident-done sequences.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA;
    logic rstB;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) busA ();
    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) busB ();

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(4096),
        .GAP_CYCLES(2)
    ) dutA (
        .clk(clk),
        .reset(rstA),
        .bus(busA)
    );

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(8),
        .GAP_CYCLES(2)
    ) dutB (
        .clk(clk),
        .reset(rstB),
        .bus(busB)
    );

    typedef struct {
        string name;
        logic rst;
        logic [3:0] v;
        logic [31:0] d;
        logic pe;
        logic pt;
        logic done;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];
    int nVec;
    int nBad;

    task automatic check(
        input string name,
        input logic [63:0] got,
        input logic [63:0] want
    );
        nVec++;
        if (got !== want) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic addVec(
        input string name,
        input logic rst, input logic [3:0] v, input logic [31:0] d,
        input logic pe, input logic pt, input logic done,
        input logic [3:0] rdy, input logic st, input logic [7:0] data,
        input logic epe, input logic ept, input logic gv,
        input logic [1:0] gid, input logic to
    );
        vec_t x;
        x.name = name;
        x.rst = rst;
        x.v = v;
        x.d = d;
        x.pe = pe;
        x.pt = pt;
        x.done = done;
        x.exp = {rdy, st, data, epe, ept, gv, gid, to};
        vecs.push_back(x);
    endtask

    function automatic logic [18:0] outsA();
        return {busA.reqReady, busA.txStart, busA.txData,
                busA.txParityEnable, busA.txParityType,
                busA.grantValid, busA.grantId, busA.timeoutError};
    endfunction

    task automatic buildTable();
        //      name rst v d pe pt done | rdy st data pe pt gv gid to
        addVec("rstIdle", 0, 4'b0000, 32'h0, 0, 0, 0,
               4'b0000, 0, 8'h00, 0, 0, 0, 2'd0, 0);
        addVec("singleAcc", 0, 4'b0100, 32'h00A5_0000, 1, 1, 0,
               4'b0100, 0, 8'h00, 0, 0, 0, 2'd0, 0);
        addVec("singleStart", 0, 4'b0000, 32'h0, 0, 0, 0,
               4'b0000, 1, 8'hA5, 1, 1, 1, 2'd2, 0);
        addVec("cfgHold", 0, 4'b0001, 32'h11, 1, 0, 0,
               4'b0000, 0, 8'hA5, 1, 1, 1, 2'd2, 0);
        addVec("doneA", 0, 4'b0001, 32'h11, 0, 0, 1,
               4'b0000, 0, 8'hA5, 1, 1, 1, 2'd2, 0);
        addVec("gapA1", 0, 4'b0001, 32'h11, 0, 0, 0,
               4'b0000, 0, 8'hA5, 1, 1, 0, 2'd2, 0);
        addVec("gapA2", 0, 4'b0001, 32'h11, 0, 0, 0,
               4'b0000, 0, 8'hA5, 1, 1, 0, 2'd2, 0);
        addVec("accR0", 0, 4'b0001, 32'h11, 0, 0, 0,
               4'b0001, 0, 8'hA5, 1, 1, 0, 2'd2, 0);
        addVec("doneIgnored", 0, 4'b0110, 32'h11, 0, 0, 1,
               4'b0000, 1, 8'h11, 0, 0, 1, 2'd0, 0);
        addVec("waitR0", 0, 4'b0110, 32'h11, 0, 0, 0,
               4'b0000, 0, 8'h11, 0, 0, 1, 2'd0, 0);
        addVec("rstMid", 1, 4'b0110, 32'h11, 0, 0, 0,
               4'b0000, 0, 8'h11, 0, 0, 1, 2'd0, 0);
        addVec("postRst", 0, 4'b1001, 32'h3300_0044, 1, 0, 0,
               4'b0001, 0, 8'h00, 0, 0, 0, 2'd0, 0);
        addVec("issueR0", 0, 4'b1000, 32'h3300_0044, 0, 0, 0,
               4'b0000, 1, 8'h44, 1, 0, 1, 2'd0, 0);
        addVec("doneB", 0, 4'b1000, 32'h3300_0044, 0, 0, 1,
               4'b0000, 0, 8'h44, 1, 0, 1, 2'd0, 0);
        addVec("gapB1", 0, 4'b1000, 32'h3300_0044, 0, 0, 0,
               4'b0000, 0, 8'h44, 1, 0, 0, 2'd0, 0);
        addVec("gapB2", 0, 4'b1000, 32'h3300_0044, 0, 0, 0,
               4'b0000, 0, 8'h44, 1, 0, 0, 2'd0, 0);
        addVec("accR3", 0, 4'b1000, 32'h3300_0044, 0, 1, 0,
               4'b1000, 0, 8'h44, 1, 0, 0, 2'd0, 0);
        addVec("issueR3", 0, 4'b0000, 32'h0, 1, 0, 0,
               4'b0000, 1, 8'h33, 0, 1, 1, 2'd3, 0);
    endtask

    int stCyc[5];
    int stId[5];
    logic [7:0] stData[5];
    int ns;
    int lastSt;
    int toCnt;
    int toCyc;
    logic gvLog[64];
    logic [3:0] rdyLog[64];
    int st0;
    int st1;
    int id1;

    initial begin
        nVec = 0;
        nBad = 0;
        rstA = 1'b1;
        rstB = 1'b1;
        busA.reqValid = '0;
        busA.reqData = '0;
        busA.cfgParityEnable = 1'b0;
        busA.cfgParityType = 1'b0;
        busA.txDone = 1'b0;
        busB.reqValid = '0;
        busB.reqData = '0;
        busB.cfgParityEnable = 1'b0;
        busB.cfgParityType = 1'b0;
        busB.txDone = 1'b0;
        buildTable();
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            rstA = vecs[i].rst;
            busA.reqValid = vecs[i].v;
            busA.reqData = vecs[i].d;
            busA.cfgParityEnable = vecs[i].pe;
            busA.cfgParityType = vecs[i].pt;
            busA.txDone = vecs[i].done;
            @(negedge clk);
            check(vecs[i].name, 64'(outsA()), 64'(vecs[i].exp));
            @(posedge clk);
            #1;
        end

        // Fairness: everyone valid, done 10 cycles after each start.
        rstA = 1'b1;
        busA.reqValid = '0;
        busA.txDone = 1'b0;
        @(posedge clk);
        #1;
        rstA = 1'b0;
        busA.reqValid = 4'hF;
        busA.reqData = 32'hC3C2_C1C0;
        ns = 0;
        lastSt = -100;
        for (int k = 0; k < 5; k++) begin
            stCyc[k] = -1000;
            stId[k] = -1;
            stData[k] = 8'h00;
        end
        for (int c = 0; c < 100 && ns < 5; c++) begin
            busA.txDone = (c == lastSt + 10);
            @(negedge clk);
            if (busA.txStart) begin
                stCyc[ns] = c;
                stId[ns] = int'(busA.grantId);
                stData[ns] = busA.txData;
                ns++;
                lastSt = c;
            end
            @(posedge clk);
            #1;
        end
        busA.reqValid = '0;
        busA.txDone = 1'b0;
        check("fairStarts", 64'(ns), 64'(5));
        check("fairFirst", 64'(stCyc[0]), 64'(1));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fairId%0d", k), 64'(stId[k]), 64'(k % 4));
            check($sformatf("fairData%0d", k), 64'(stData[k]),
                  64'(8'hC0 + 8'(k % 4)));
        end
        for (int k = 1; k < 5; k++) begin
            check($sformatf("fairGap%0d", k),
                  64'(stCyc[k] - stCyc[k-1]), 64'(14));
        end

        // Watchdog on dutB (limit 8), txDone never asserted.
        rstB = 1'b0;
        busB.reqValid = 4'b0011;
        busB.reqData = 32'h0000_BBAA;
        ns = 0;
        st0 = -1000;
        st1 = -1000;
        id1 = -1;
        toCnt = 0;
        toCyc = -1000;
        for (int c = 0; c < 60 && ns < 2; c++) begin
            @(negedge clk);
            gvLog[c] = busB.grantValid;
            rdyLog[c] = busB.reqReady;
            if (busB.timeoutError) begin
                toCnt++;
                toCyc = c;
            end
            if (busB.txStart) begin
                if (ns == 0) st0 = c;
                else begin
                    st1 = c;
                    id1 = int'(busB.grantId);
                end
                ns++;
            end
            @(posedge clk);
            #1;
        end
        check("toPulses", 64'(toCnt), 64'(1));
        check("toDelay", 64'(toCyc - st0), 64'(8));
        check("toNextStart", 64'(st1 - st0), 64'(12));
        check("toNextId", 64'(id1), 64'(1));
        check("toGvHeld", 64'(gvLog[(st0 + 8) & 63]), 64'(1));
        check("toGvFall", 64'(gvLog[(st0 + 9) & 63]), 64'(0));
        check("toGapRdy", 64'(rdyLog[(st0 + 10) & 63]), 64'(0));
        check("toNextRdy", 64'(rdyLog[(st0 + 11) & 63]), 64'(4'b0010));

        // Done arriving on the exact watchdog limit cycle.
        rstB = 1'b1;
        busB.reqValid = '0;
        @(posedge clk);
        #1;
        rstB = 1'b0;
        busB.reqValid = 4'b0100;
        busB.reqData = 32'h005A_0000;
        st0 = -1000;
        toCnt = 0;
        stData[0] = 8'h00;
        for (int c = 0; c < 30; c++) begin
            busB.txDone = (c == st0 + 8);
            if (st0 >= 0) busB.reqValid = '0;
            @(negedge clk);
            gvLog[c] = busB.grantValid;
            if (busB.timeoutError) toCnt++;
            if (busB.txStart && st0 < 0) begin
                st0 = c;
                stData[0] = busB.txData;
            end
            @(posedge clk);
            #1;
        end
        busB.txDone = 1'b0;
        check("coStart", 64'(st0), 64'(1));
        check("coData", 64'(stData[0]), 64'(8'h5A));
        check("coNoTimeout", 64'(toCnt), 64'(0));
        check("coGvHeld", 64'(gvLog[(st0 + 8) & 63]), 64'(1));
        check("coGvFall", 64'(gvLog[(st0 + 9) & 63]), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
